// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   Registered next-PC generator for a 5-stage MIPS pipeline. Holds the
//   word-addressed PC and picks the next fetch address from these sources:
//   sequential, IF-stage J, ID-stage taken branch and ID-stage JR. A redirect
//   that arrives while the pipe is stalled is parked in a pending register and
//   applied on the first unstalled cycle. Each applied redirect raises a
//   one-cycle registered IF squash and bumps a saturating counter.
//
//   Optional feature macro: NPC_BTB_EN
//     Adds a direct-mapped branch target buffer that predicts taken branches
//     at fetch and recovers from mispredictions signalled from ID.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   stall             hold PC this cycle
//   if_jump/if_target J/JAL in IF and its 26-bit target field
//   id_br_taken       ID branch resolved taken
//   id_is_branch      ID holds a conditional branch (BTB build only)
//   id_pred_taken     prediction carried with the ID instruction (BTB build only)
//   id_pc, id_imm16   ID instruction word address and branch word offset
//   id_jr/id_jr_addr  JR/JALR in ID and its byte target from the register file
//   pc                current fetch word address
//   pred_taken        BTB hit for the current pc (0 without the BTB)
//   if_flush          squash the IF instruction (registered)
//   redirect_cnt      number of applied redirects, saturating
module pc_gen_unit #(
   parameter int unsigned     PC_W      = 30,
   parameter logic [PC_W-1:0] RESET_PC  = 'h0000_0C00,
   parameter int unsigned     CNT_W     = 16,
   parameter int unsigned     BTB_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             if_jump,
   input  logic [25:0]      if_target,
   input  logic             id_br_taken,
   input  logic             id_is_branch,
   input  logic             id_pred_taken,
   input  logic [PC_W-1:0]  id_pc,
   input  logic [15:0]      id_imm16,
   input  logic             id_jr,
   input  logic [31:0]      id_jr_addr,
   output logic [PC_W-1:0]  pc,
   output logic             pred_taken,
   output logic             if_flush,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam int unsigned IDX_W = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;

   logic [PC_W-1:0]  pc_q, pc_d;
   logic             pend_vld_q, pend_vld_d;
   logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
   logic             if_flush_q, if_flush_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [PC_W-1:0]  br_tgt, jr_tgt, j_tgt, seq_tgt, mis_tgt, redir_tgt;
   logic             redir_req;
   logic             br_redir;
   logic             mispredict;
   logic             btb_hit;
   logic [PC_W-1:0]  btb_tgt;

   // Target arithmetic wraps naturally at PC_W bits.
   assign br_tgt  = id_pc + 1'b1 + {{(PC_W-16){id_imm16[15]}}, id_imm16};
   assign jr_tgt  = id_jr_addr[PC_W+1:2];
   assign j_tgt   = {pc_q[PC_W-1:26], if_target};
   assign seq_tgt = pc_q + 1'b1;
   assign mis_tgt = id_pc + 1'b1;

`ifdef NPC_BTB_EN
   localparam int unsigned TAG_W = PC_W - IDX_W;

   logic [BTB_DEPTH-1:0] btb_vld_q, btb_vld_d;
   logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
   logic [PC_W-1:0]      btb_tgt_q [BTB_DEPTH];
   logic [IDX_W-1:0]     rd_idx, wr_idx;
   logic                 br_upd, btb_wr;

   assign rd_idx     = pc_q[IDX_W-1:0];
   assign wr_idx     = id_pc[IDX_W-1:0];
   // Lookup reads the registered table, so a same-cycle write is not visible.
   assign btb_hit    = btb_vld_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[PC_W-1:IDX_W]);
   assign btb_tgt    = btb_tgt_q[rd_idx];
   assign br_upd     = id_is_branch && !stall;
   assign btb_wr     = br_upd && id_br_taken;
   assign mispredict = br_upd && !id_br_taken && id_pred_taken;
   // A correctly predicted taken branch was already fetched from the BTB
   // target, which is exact, so it needs no redirect.
   assign br_redir   = id_br_taken && !(id_is_branch && id_pred_taken);

   always_comb begin
      btb_vld_d = btb_vld_q;
      if (btb_wr) begin
         btb_vld_d[wr_idx] = 1'b1;
      end else if (mispredict) begin
         btb_vld_d[wr_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btb_vld_q <= '0;
      end else begin
         btb_vld_q <= btb_vld_d;
      end
   end

   // Tag and target payload need no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (btb_wr) begin
         btb_tag_q[wr_idx] <= id_pc[PC_W-1:IDX_W];
         btb_tgt_q[wr_idx] <= br_tgt;
      end
   end

   logic unused_ok;
   assign unused_ok = ^id_jr_addr;
`else
   assign btb_hit    = 1'b0;
   assign btb_tgt    = '0;
   assign mispredict = 1'b0;
   assign br_redir   = id_br_taken;

   logic unused_ok;
   assign unused_ok = ^{id_is_branch, id_pred_taken, id_jr_addr, 1'(IDX_W)};
`endif

   assign redir_req = id_jr || br_redir || mispredict;

   always_comb begin
      redir_tgt = mis_tgt;
      if (id_jr) begin
         redir_tgt = jr_tgt;
      end else if (br_redir) begin
         redir_tgt = br_tgt;
      end
   end

   always_comb begin
      pc_d       = pc_q;
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      if_flush_d = 1'b0;
      cnt_d      = cnt_q;

      if (!stall && redir_req) begin
         // A fresh request beats an older pending one.
         pc_d       = redir_tgt;
         pend_vld_d = 1'b0;
         if_flush_d = 1'b1;
      end else if (!stall && pend_vld_q) begin
         pc_d       = pend_tgt_q;
         pend_vld_d = 1'b0;
         if_flush_d = 1'b1;
      end else if (stall) begin
         // IF instruction will be re-presented, so if_jump is ignored here.
         if (redir_req) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redir_tgt;
         end
      end else if (if_jump) begin
         pc_d = j_tgt;
      end else if (btb_hit) begin
         pc_d = btb_tgt;
      end else begin
         pc_d = seq_tgt;
      end

      if (if_flush_d && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
         if_flush_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
         if_flush_q <= if_flush_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pc           = pc_q;
   assign pred_taken   = btb_hit;
   assign if_flush     = if_flush_q;
   assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        if_jump;
   logic [25:0] if_target;
   logic        id_br_taken;
   logic        id_is_branch;
   logic        id_pred_taken;
   logic [29:0] id_pc;
   logic [15:0] id_imm16;
   logic        id_jr;
   logic [31:0] id_jr_addr;

   logic [29:0] pc, pc2;
   logic        pred_taken, pred2;
   logic        if_flush, flush2;
   logic [15:0] redirect_cnt;
   logic [1:0]  cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [29:0] m_pc;
   bit          m_pend_v;
   logic [29:0] m_pend_tgt;
   bit          m_flush;
   int          m_cnt;
   logic [29:0] exp_q[$];

   pc_gen_unit u_dut (
      .clk(clk), .rst(rst), .stall(stall), .if_jump(if_jump), .if_target(if_target),
      .id_br_taken(id_br_taken), .id_is_branch(id_is_branch), .id_pred_taken(id_pred_taken),
      .id_pc(id_pc), .id_imm16(id_imm16), .id_jr(id_jr), .id_jr_addr(id_jr_addr),
      .pc(pc), .pred_taken(pred_taken), .if_flush(if_flush), .redirect_cnt(redirect_cnt)
   );

   pc_gen_unit #(.CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .stall(stall), .if_jump(if_jump), .if_target(if_target),
      .id_br_taken(id_br_taken), .id_is_branch(id_is_branch), .id_pred_taken(id_pred_taken),
      .id_pc(id_pc), .id_imm16(id_imm16), .id_jr(id_jr), .id_jr_addr(id_jr_addr),
      .pc(pc2), .pred_taken(pred2), .if_flush(flush2), .redirect_cnt(cnt2)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 0; if_jump = 0; if_target = '0; id_br_taken = 0; id_is_branch = 0;
      id_pred_taken = 0; id_pc = '0; id_imm16 = '0; id_jr = 0; id_jr_addr = '0;
   endtask

   // Behavioural next-state rule: a redirect (new one first, else a parked
   // one) applies when unstalled; a stall parks new redirects; otherwise J or
   // sequential fetch.
   task automatic model_step();
      bit          req;
      logic [29:0] tgt;
      int          off;
      off = int'($signed(id_imm16));
      req = id_jr || id_br_taken;
      if (id_jr) tgt = id_jr_addr[31:2];
      else       tgt = 30'(int'(id_pc) + 1 + off);
      m_flush = 0;
      if (!stall && (req || m_pend_v)) begin
         m_pc     = req ? tgt : m_pend_tgt;
         m_pend_v = 0;
         m_flush  = 1;
         m_cnt++;
      end else if (stall) begin
         if (req) begin
            m_pend_v   = 1;
            m_pend_tgt = tgt;
         end
      end else if (if_jump) begin
         m_pc = {m_pc[29:26], if_target};
      end else begin
         m_pc = m_pc + 30'd1;
      end
   endtask

   task automatic tick();
      model_step();
      exp_q.push_back(m_pc);
      @(posedge clk); #1;
      check("pc", 32'(pc), 32'(exp_q.pop_front()));
      check("pc_w2", 32'(pc2), 32'(m_pc));
      check("if_flush", 32'(if_flush), 32'(m_flush));
      check("if_flush_w2", 32'(flush2), 32'(m_flush));
      check("redirect_cnt", 32'(redirect_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("redirect_cnt_w2", 32'(cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
`ifndef NPC_BTB_EN
      check("pred_taken", 32'(pred_taken), 32'd0);
      check("pred_taken_w2", 32'(pred2), 32'd0);
`endif
   endtask

   task automatic raw_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      // reset pulse in the middle of a cycle
      #3 rst = 1'b1;
      #1;
      check("reset_pc", 32'(pc), 32'h0000_0C00);
      check("reset_flush", 32'(if_flush), 32'd0);
      check("reset_cnt", 32'(redirect_cnt), 32'd0);
      #3 rst = 1'b0;
      m_pc = 30'h0000_0C00; m_pend_v = 0; m_pend_tgt = '0; m_flush = 0; m_cnt = 0;
      tick(); check("seq1", 32'(pc), 32'hC01);
      tick(); check("seq2", 32'(pc), 32'hC02);
      tick(); check("seq3", 32'(pc), 32'hC03);

      // taken branch: C05 + 1 - 2
      id_pc = 30'hC05; id_imm16 = 16'hFFFE; id_br_taken = 1;
      tick(); check("br_pc", 32'(pc), 32'hC04); check("br_flush", 32'(if_flush), 32'd1);
      idle_inputs();
      tick(); check("br_flush_drop", 32'(if_flush), 32'd0); check("br_cnt", 32'(redirect_cnt), 32'd1);

      // jump from C02
      id_jr = 1; id_jr_addr = 32'h0000_3008;
      tick(); idle_inputs();
      if_jump = 1; if_target = 26'h000_0D00;
      tick(); check("j_pc", 32'(pc), 32'hD00); check("j_flush", 32'(if_flush), 32'd0);
      idle_inputs();

      // stalled branch to C20, held three cycles
      stall = 1; id_br_taken = 1; id_pc = 30'hC10; id_imm16 = 16'h000F;
      tick(); id_br_taken = 0;
      tick(); tick();
      check("stall_hold", 32'(pc), 32'hD00);
      stall = 0;
      tick(); check("stall_apply", 32'(pc), 32'hC20); check("stall_flush", 32'(if_flush), 32'd1);

      // jr beats branch and jump
      id_jr = 1; id_jr_addr = 32'h0000_4000; id_br_taken = 1; id_pc = 30'h100; if_jump = 1;
      tick(); check("prio_pc", 32'(pc), 32'h1000);
      idle_inputs();
      id_jr = 1; id_jr_addr = 32'hFFFF_FFFC;
      tick(); check("top_pc", 32'(pc), 32'h3FFF_FFFF);
      idle_inputs();
      tick(); check("wrap_pc", 32'(pc), 32'h0);
      check("cnt_w2_sat", 32'(cnt2), 32'd3);
      check("cnt_five", 32'(redirect_cnt), 32'd5);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         stall       = ($urandom_range(0, 9) < 3);
         id_jr       = ($urandom_range(0, 9) == 0);
         id_br_taken = ($urandom_range(0, 19) < 3);
         if_jump     = ($urandom_range(0, 19) < 3);
         if_target   = 26'($urandom);
         id_pc       = 30'($urandom);
         id_imm16    = 16'($urandom);
         id_jr_addr  = $urandom;
         tick();
      end
      idle_inputs();
      tick();

`ifdef NPC_BTB_EN
      // train BTB with branch at C05 -> C10
      id_jr = 1; id_jr_addr = 32'h0000_3014;
      tick(); idle_inputs();
      id_is_branch = 1; id_br_taken = 1; id_pc = 30'hC05; id_imm16 = 16'h000A;
      tick(); check("btb_train_pc", 32'(pc), 32'hC10);
      idle_inputs();
      id_jr = 1; id_jr_addr = 32'h0000_3014;
      tick(); idle_inputs();
      check("btb_pred", 32'(pred_taken), 32'd1);
      raw_edge();
      check("btb_next", 32'(pc), 32'hC10);
      check("btb_no_flush", 32'(if_flush), 32'd0);
      id_is_branch = 1; id_br_taken = 0; id_pred_taken = 1; id_pc = 30'hC05;
      raw_edge();
      check("mis_pc", 32'(pc), 32'hC06);
      check("mis_flush", 32'(if_flush), 32'd1);
      idle_inputs();
      id_jr = 1; id_jr_addr = 32'h0000_3014;
      raw_edge(); idle_inputs();
      check("mis_pc_back", 32'(pc), 32'hC05);
      check("mis_invalid", 32'(pred_taken), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Registered next-PC generator for the hazard-aware 5-stage MIPS pipeline. It owns the PC register and chooses the next fetch address from these sources: sequential, IF-stage J, ID-stage taken branch, ID-stage JR. It holds redirects that arrive while stalled, emits a one-cycle IF squash pulse, and counts applied redirects. An optional direct-mapped BTB predicts taken branches at fetch.

Parameters:
PC_W, 30, word-address width (PC[PC_W+1:2]); must be >= 27
RESET_PC, 30'h00000C00, word address loaded on reset (byte 0x00003000)
CNT_W, 16, width of saturating redirect counter
BTB_DEPTH, 16, BTB entries, power of 2, >= 2 (used only with NPC_BTB_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold PC (load-use / ID hazard)
if_jump  in  1  IF instruction is J/JAL
if_target  in  26  J-format target field
id_br_taken  in  1  ID branch resolved taken
id_is_branch  in  1  ID holds a conditional branch
id_pred_taken  in  1  pred_taken value carried with the ID instruction
id_pc  in  PC_W  word address of ID instruction
id_imm16  in  16  branch offset (words)
id_jr  in  1  ID instruction is JR/JALR
id_jr_addr  in  32  byte address from register file
pc  out  PC_W  current fetch word address
pred_taken  out  1  BTB hit for current pc (0 without macro)
if_flush  out  1  squash IF instruction, registered
redirect_cnt  out  CNT_W  applied redirects, saturating

Behaviour:
- Reset (async):
  - pc=RESET_PC; if_flush=0; redirect_cnt=0.
  - Pending-redirect valid cleared; all BTB valid bits cleared.
- Target arithmetic, all modulo 2^PC_W:
  - br_tgt = id_pc + 1 + sign_extend(id_imm16).
  - jr_tgt = id_jr_addr[PC_W+1:2].
  - j_tgt = {pc[PC_W-1:26], if_target}.
  - seq = pc + 1; wraps from all-ones to 0.
- A redirect request exists in a cycle if id_jr, id_br_taken, or a BTB mispredict (feature only) is asserted.
- Redirect target priority: id_jr > id_br_taken > mispredict.
- Next-pc priority per cycle:
  1. Pending redirect valid and stall=0: pc<=pending target; clear pending.
  2. Redirect request and stall=0: pc<=redirect target.
  3. Redirect request and stall=1: latch target into pending (overwrite any older pending); pc held.
  4. stall=1: pc held; if_jump ignored, since the IF instruction is re-presented.
  5. if_jump: pc<=j_tgt.
  6. BTB hit (feature): pc<=BTB target.
  7. Otherwise pc<=seq.
- If a new redirect request arrives in the same cycle that a pending redirect is applied (case 1), the new request wins. Case 1 then behaves as case 2, and pending is cleared.
- if_flush:
  - Registered; equals 1 in exactly the cycle after pc is loaded from a redirect (cases 1/2), else 0.
  - Not asserted for J, BTB redirects, or when a redirect is only latched.
- redirect_cnt: +1 per cycle where case 1 or 2 applies; saturates at all-ones.
- Latency:
  - Redirect to pc: 1 cycle when unstalled.
  - When stalled: 1 cycle after the first stall=0 cycle.

Optional Feature:
Macro NPC_BTB_EN.
- Defined:
  - BTB_DEPTH-entry direct-mapped table with valid, tag and target fields.
    - Index: pc[log2(BTB_DEPTH)-1:0].
    - Tag: remaining upper pc bits.
    - Target: PC_W bits.
  - pred_taken = combinational hit on current pc.
  - When id_is_branch and the branch is not stalled:
    - id_br_taken=1: write entry {id_pc, br_tgt}.
    - id_br_taken=0 and id_pred_taken=1: mispredict. Redirect to id_pc+1 (counts, flushes) and invalidate the entry.
    - id_br_taken=1 and id_pred_taken=1: no redirect. The stored target is exact.
  - Write and lookup at the same index in the same cycle: lookup sees the old contents.
- Undefined:
  - No table; pred_taken tied 0.
  - id_is_branch and id_pred_taken are ignored; mispredict is never raised.

Test Plan:
1. Reset: rst pulse mid-cycle, then release for 3 cycles -> pc 0xC00 immediately, then 0xC01, 0xC02, 0xC03; if_flush=0; redirect_cnt=0.
2. Taken branch: id_pc=0xC05, id_imm16=16'hFFFE, id_br_taken=1 -> next pc=0xC04; if_flush=1 for one cycle; redirect_cnt=1.
3. Jump: pc=0xC02, if_jump=1, if_target=26'h0000D00 -> pc=0xD00; if_flush stays 0.
4. Stalled redirect: stall=1 for 3 cycles, id_br_taken in the first cycle with target 0xC20 -> pc held through the stall. First stall=0 cycle -> pc=0xC20, then if_flush=1 for one cycle.
5. Priority and wrap:
   - id_jr (addr 0x00004000), id_br_taken and if_jump all in one cycle -> pc=0x1000.
   - pc=30'h3FFFFFFF, no events -> pc=0.
   - CNT_W=2 with 5 redirects -> redirect_cnt=3.
6. NPC_BTB_EN:
   - Branch at 0xC05 taken to 0xC10 -> revisit 0xC05 gives pred_taken=1, next pc=0xC10.
   - Then id_br_taken=0 with id_pred_taken=1 -> pc=0xC06, if_flush=1, entry invalidated.
